// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction ROM address/data, execute redirects and
// the {pc, instruction} delivery handshake towards decode.
interface inst_fetch_if;
  logic [31:0] inst_addr;
  logic [31:0] inst_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_err;

  modport master (
    output inst_addr,
    input  inst_i,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_inst,
    output if_err
  );

  modport slave (
    input  inst_addr,
    output inst_i,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_inst,
    input  if_err
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives a one-cycle-latency ROM and
// buffers returned words in a 2-entry FIFO so decode stalls never drop data.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IROM_SPACE = 4096
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam logic [31:0] IROM_LIMIT = 32'(IROM_SPACE * 4);
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } entry_t;

  logic [31:0] pc_q;
  logic        inflight_valid_q;
  logic [31:0] inflight_pc_q;
  logic        inflight_err_q;
  entry_t      head_q, tail_q, head_d, tail_d, ret_entry;
  logic [1:0]  count_q, count_d, remaining;
  logic [2:0]  occupancy;
  logic        pop, push, issue;

  // Issue only when everything already owed to the FIFO, minus this cycle's
  // pop, leaves a free slot; this is what makes a push into a full FIFO impossible.
  always_comb begin
    pop       = (count_q != 2'd0) & bus.if_ready;
    push      = inflight_valid_q & ~bus.redirect_valid;
    occupancy = {1'b0, count_q} + {2'b00, inflight_valid_q} - {2'b00, pop};
    issue     = ~bus.redirect_valid & (occupancy < 3'd2);
    remaining = count_q - {1'b0, pop};
    ret_entry = '{pc: inflight_pc_q,
                  inst: inflight_err_q ? NOP_INST : bus.inst_i,
                  err: inflight_err_q};
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (bus.redirect_valid) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        head_d = tail_q;
      end
      if (push) begin
        if (remaining == 2'd0) begin
          head_d = ret_entry;
        end else begin
          tail_d = ret_entry;
        end
      end
      count_d = remaining + {1'b0, push};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= 32'h0;
      inflight_err_q   <= 1'b0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= 2'd0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      inflight_valid_q <= issue;
      if (bus.redirect_valid) begin
        pc_q <= {bus.redirect_pc[31:2], 2'b00};
      end else if (issue) begin
        pc_q <= pc_q + 32'd4;
      end
      if (issue) begin
        inflight_pc_q  <= pc_q;
        inflight_err_q <= (pc_q >= IROM_LIMIT);
      end
    end
  end

  assign bus.inst_addr = pc_q;
  assign bus.if_valid  = (count_q != 2'd0);
  assign bus.if_pc     = head_q.pc;
  assign bus.if_inst   = head_q.inst;
  assign bus.if_err    = head_q.err;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: a PC-stream scoreboard plus restart-bubble
// timing model checks every delivered {pc, inst, err} and the if_valid profile.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] ROM_BYTES = 32'd16384;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(RESET_PC), .IROM_SPACE(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word n holds n; out-of-range reads return junk the DUT must replace.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return (addr < ROM_BYTES) ? {2'b00, addr[31:2]} : 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) bus.inst_i <= rom_word(bus.inst_addr);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rv,
                               input logic [31:0] rp, input logic rdy);
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.if_ready       = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reference model: after any restart (reset release or redirect) decode sees
  // two empty cycles, then an unbroken stream of pc, pc+4, ... regardless of stalls.
  logic        known;
  logic        after_rst;
  int          warm;
  logic [31:0] exp_pc;

  initial begin
    known     = 1'b0;
    after_rst = 1'b0;
    warm      = 0;
    exp_pc    = RESET_PC;
  end

  always @(negedge clk) begin
    if (known) begin
      checkOutput("valid", 32'(bus.if_valid), 32'(warm >= 2));
      if (after_rst) begin
        checkOutput("rst_addr", bus.inst_addr, RESET_PC);
        checkOutput("rst_pc", bus.if_pc, 32'h0);
        checkOutput("rst_inst", bus.if_inst, 32'h0);
        checkOutput("rst_err", 32'(bus.if_err), 32'h0);
      end
      if (warm >= 2 && bus.if_ready) begin
        checkOutput("pc", bus.if_pc, exp_pc);
        checkOutput("inst", bus.if_inst,
                    (exp_pc < ROM_BYTES) ? (exp_pc >> 2) : 32'h0000_0013);
        checkOutput("err", 32'(bus.if_err), 32'(exp_pc >= ROM_BYTES));
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (rst) begin
      known     = 1'b1;
      after_rst = 1'b1;
      warm      = 0;
      exp_pc    = RESET_PC;
    end else begin
      after_rst = 1'b0;
      if (bus.redirect_valid) begin
        warm   = 0;
        exp_pc = {bus.redirect_pc[31:2], 2'b00};
      end else if (warm < 2) begin
        warm++;
      end
    end
  end

  logic [31:0] target;
  int          sel;

  initial begin
    total = 0;
    bad   = 0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 32'h0, i < 5 || i >= 9);

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    applyStimulus(1'b0, 1'b1, 32'h0000_3FF0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, i != 4);

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0800, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 99));
      case ($urandom_range(0, 3))
        0:       target = $urandom_range(0, 16383);
        1:       target = 32'h0000_3FE0 + $urandom_range(0, 63);
        2:       target = $urandom;
        default: target = 32'hFFFF_FFE0 + $urandom_range(0, 31);
      endcase
      applyStimulus(sel < 2, sel >= 2 && sel < 8, target, $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
